// File: rtl/wm_phase_timer.sv
// wm_phase_timer
// Countdown responder for the washer control FSM's phase-timer requests.
// A phase duration (in 100 ms counts) is loaded together with a 2-bit step
// index and counted down on a prescaled tick. On expiry, the o_response bit
// selected by the latched step pulses for one cycle. o_time carries the
// remaining counts to the time-to-digits/display path.
//
// Optional feature macro: WM_PAUSE_EN
//   When defined, the i_pause input is added. While it is high in RUN, the
//   prescaler and o_time are frozen. Load and abort still act during pause.
//   When undefined, the port does not exist and counting never freezes.

module wm_phase_timer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 10,
    parameter int ACCEL_MULT = 60,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timeshift,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_state,
    input  logic [1:0]       i_step,
`ifdef WM_PAUSE_EN
    input  logic             i_pause,
`endif
    output logic [3:0]       o_response,
    output logic [CNT_W-1:0] o_time,
    output logic             o_busy
);

    // Prescaler divide ratios. The fast ratio never drops below one clock.
    localparam int DIV          = CLK_HZ / TICK_HZ;
    localparam int DIV_FAST_RAW = DIV / ACCEL_MULT;
    localparam int DIV_FAST     = (DIV_FAST_RAW < 1) ? 1 : DIV_FAST_RAW;

    // The prescaler never holds more than DIV-1, so clog2(DIV) bits suffice.
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] LIM_SLOW_M1 = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] LIM_FAST_M1 = PRE_W'(DIV_FAST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   time_reg, time_next;
    logic [PRE_W-1:0]   pre_reg, pre_next;
    logic [1:0]         step_reg, step_next;
    logic               start_reg, start_next;
    logic [3:0]         response_reg, response_next;
    logic               busy_reg, busy_next;

    logic [PRE_W-1:0]   lim_m1;
    logic               tick;
    logic               load;
    logic               paused;
    logic               expire;

`ifdef WM_PAUSE_EN
    assign paused = i_pause;
`else
    assign paused = 1'b0;
`endif

    // timeshift is active-low: 0 selects the accelerated rate.
    assign lim_m1 = timeshift ? LIM_SLOW_M1 : LIM_FAST_M1;

    // The compare is ">=" so that switching to the fast rate while the
    // prescaler is already past the fast limit ticks on the next edge.
    assign tick = (pre_reg >= lim_m1);

    // A load is a rising i_start, or a new step index while i_start stays high.
    assign load = i_start & (~start_reg | (i_step != step_reg));

    // Next-state and datapath decisions, in priority order: load, abort,
    // expiry, then tick decrement.
    always_comb begin
        state_next = state_reg;
        time_next  = time_reg;
        pre_next   = pre_reg;
        step_next  = step_reg;
        start_next = i_start;
        expire     = 1'b0;

        if (load) begin
            // A load in RUN abandons the running phase without a response.
            state_next = RUN;
            time_next  = i_state;
            step_next  = i_step;
            pre_next   = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (!i_start) begin
                        state_next = IDLE;
                        time_next  = '0;
                        pre_next   = '0;
                    end else if (!paused) begin
                        if (time_reg == '0) begin
                            // A zero-length phase expires one cycle after its load.
                            expire     = 1'b1;
                            state_next = HOLD;
                            pre_next   = '0;
                        end else if (tick) begin
                            pre_next = '0;
                            if (time_reg == CNT_W'(1)) begin
                                time_next  = '0;
                                expire     = 1'b1;
                                state_next = HOLD;
                            end else begin
                                time_next = time_reg - CNT_W'(1);
                            end
                        end else begin
                            pre_next = pre_reg + PRE_W'(1);
                        end
                    end
                end
                HOLD: begin
                    time_next = '0;
                    pre_next  = '0;
                    if (!i_start) begin
                        state_next = IDLE;
                    end
                end
                IDLE: begin
                    time_next = '0;
                    pre_next  = '0;
                end
                default: begin
                    state_next = IDLE;
                    time_next  = '0;
                    pre_next   = '0;
                end
            endcase
        end

        busy_next = (state_next == RUN);
    end

    // One-hot response decode. On expiry, the bit matches the latched step.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_resp
            assign response_next[gi] = expire & (step_reg == 2'(gi));
        end
    endgenerate

    // State and datapath registers. Reset clears every output at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            time_reg     <= '0;
            pre_reg      <= '0;
            step_reg     <= 2'd0;
            start_reg    <= 1'b0;
            response_reg <= 4'b0000;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            time_reg     <= time_next;
            pre_reg      <= pre_next;
            step_reg     <= step_next;
            start_reg    <= start_next;
            response_reg <= response_next;
            busy_reg     <= busy_next;
        end
    end

    assign o_response = response_reg;
    assign o_time     = time_reg;
    assign o_busy     = busy_reg;

endmodule

// File: tb/tb_wm_phase_timer.sv
// tb_wm_phase_timer
// Scoreboard bench for wm_phase_timer using DIV=10 and DIV_FAST=2.
// Each scenario pushes the expected response pulses, with their cycle
// numbers, into a queue. A monitor pops one entry for every pulse the DUT
// emits. Define WM_PAUSE_EN to also exercise the pause input.

module tb_wm_phase_timer;

    localparam int CNT_W = 16;

    typedef struct {
        logic [3:0] resp;
        int         cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             timeshift = 1'b1;
    logic             i_start = 1'b0;
    logic [CNT_W-1:0] i_state = '0;
    logic [1:0]       i_step = 2'd0;
`ifdef WM_PAUSE_EN
    logic             i_pause = 1'b0;
`endif
    logic [3:0]       o_response;
    logic [CNT_W-1:0] o_time;
    logic             o_busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    wm_phase_timer #(
        .CLK_HZ(100),
        .TICK_HZ(10),
        .ACCEL_MULT(5),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .timeshift(timeshift),
        .i_start(i_start),
        .i_state(i_state),
        .i_step(i_step),
`ifdef WM_PAUSE_EN
        .i_pause(i_pause),
`endif
        .o_response(o_response),
        .o_time(o_time),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && o_response !== 4'b0000) begin
            $display("pulse resp=%b cycle=%0d", o_response, cyc);
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_pulse: got resp=%b at cycle %0d, required none", o_response, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checks = checks + 1;
                if (o_response !== mon_e.resp) begin
                    errors = errors + 1;
                    $display("FAIL pulse_value: got %b, required %b", o_response, mon_e.resp);
                end
                checks = checks + 1;
                if (cyc != mon_e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL pulse_cycle: got %0d, required %0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input logic [3:0] resp, input int at);
        exp_t e;
        e.resp = resp;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        int base;
        rst = 1'b1;
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (o_time !== '0 || o_busy !== 1'b0 || o_response !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL reset_state: got time=%0d busy=%b resp=%b, required 0/0/0000", o_time, o_busy, o_response);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        timeshift = 1'b0;
        i_state = 16'd8;
        i_step = 2'd0;
        i_start = 1'b1;
        base = cyc + 1;
        for (int k = 0; k <= 6; k++) @(negedge clk);
        checks = checks + 1;
        if (o_time !== 16'd5) begin
            errors = errors + 1;
            $display("FAIL reset_prerun_time: got %0d, required 5", o_time);
        end
        rst = 1'b1;
        i_start = 1'b0;
        #1;
        checks = checks + 1;
        if (o_time !== '0 || o_busy !== 1'b0 || o_response !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL reset_async: got time=%0d busy=%b resp=%b, required 0/0/0000", o_time, o_busy, o_response);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        timeshift = 1'b1;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (o_time !== '0 || o_busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_after: got time=%0d busy=%b, required 0/0 (base %0d)", o_time, o_busy, base);
        end
    endtask

    task automatic test_normal();
        int base;
        logic [CNT_W-1:0] exp_time;
        @(negedge clk);
        timeshift = 1'b1;
        i_state = 16'd3;
        i_step = 2'd0;
        i_start = 1'b1;
        base = cyc + 1;
        push_exp(4'b0001, base + 30);
        for (int k = 0; k <= 31; k++) begin
            @(negedge clk);
            if (k % 10 == 0) begin
                exp_time = CNT_W'(3 - k / 10);
                checks = checks + 1;
                if (o_time !== exp_time) begin
                    errors = errors + 1;
                    $display("FAIL normal_time_k%0d: got %0d, required %0d", k, o_time, exp_time);
                end
            end
            if (k == 0 || k == 30) begin
                checks = checks + 1;
                if (o_busy !== (k == 0)) begin
                    errors = errors + 1;
                    $display("FAIL normal_busy_k%0d: got %b, required %b", k, o_busy, (k == 0));
                end
            end
        end
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL normal_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_fast();
        int base;
        logic [CNT_W-1:0] exp_time;
        @(negedge clk);
        timeshift = 1'b0;
        i_state = 16'd3;
        i_step = 2'd0;
        i_start = 1'b1;
        base = cyc + 1;
        push_exp(4'b0001, base + 6);
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 6) begin
                exp_time = CNT_W'(3 - k / 2);
                checks = checks + 1;
                if (o_time !== exp_time) begin
                    errors = errors + 1;
                    $display("FAIL fast_time_k%0d: got %0d, required %0d", k, o_time, exp_time);
                end
            end
        end
        i_start = 1'b0;
        timeshift = 1'b1;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL fast_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_chain();
        int base;
        logic [3:0] onehot;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            timeshift = 1'b1;
            i_state = 16'd2;
            i_step = 2'(s);
            i_start = 1'b1;
            base = cyc + 1;
            onehot = 4'b0001 << s;
            push_exp(onehot, base + 20);
            for (int k = 0; k <= 20; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    checks = checks + 1;
                    if (o_time !== 16'd2 || o_busy !== 1'b1) begin
                        errors = errors + 1;
                        $display("FAIL chain_load_s%0d: got time=%0d busy=%b, required 2/1", s, o_time, o_busy);
                    end
                end
            end
        end
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL chain_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_zero();
        int base;
        @(negedge clk);
        i_state = 16'd0;
        i_step = 2'd3;
        i_start = 1'b1;
        base = cyc + 1;
        push_exp(4'b1000, base + 1);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k <= 1) begin
                checks = checks + 1;
                if (o_busy !== (k == 0) || o_time !== '0) begin
                    errors = errors + 1;
                    $display("FAIL zero_k%0d: got busy=%b time=%0d, required %b/0", k, o_busy, o_time, (k == 0));
                end
            end
        end
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL zero_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        timeshift = 1'b1;
        i_state = 16'd4;
        i_step = 2'd1;
        i_start = 1'b1;
        for (int k = 0; k <= 20; k++) @(negedge clk);
        checks = checks + 1;
        if (o_time !== 16'd2) begin
            errors = errors + 1;
            $display("FAIL abort_pre_time: got %0d, required 2", o_time);
        end
        i_start = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (o_time !== '0 || o_busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL abort_idle: got time=%0d busy=%b, required 0/0", o_time, o_busy);
        end
        repeat (45) @(negedge clk);
        checks = checks + 1;
        if (o_time !== '0 || exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL abort_settle: got time=%0d pending=%0d, required 0/0", o_time, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reload();
        int base;
        @(negedge clk);
        timeshift = 1'b1;
        i_state = 16'd5;
        i_step = 2'd0;
        i_start = 1'b1;
        for (int k = 0; k <= 15; k++) @(negedge clk);
        checks = checks + 1;
        if (o_time !== 16'd4) begin
            errors = errors + 1;
            $display("FAIL reload_pre_time: got %0d, required 4", o_time);
        end
        i_step = 2'd2;
        i_state = 16'd1;
        base = cyc + 1;
        push_exp(4'b0100, base + 10);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks = checks + 1;
                if (o_time !== 16'd1) begin
                    errors = errors + 1;
                    $display("FAIL reload_time: got %0d, required 1", o_time);
                end
            end
        end
        repeat (45) @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL reload_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_switch();
        int base;
        @(negedge clk);
        timeshift = 1'b1;
        i_state = 16'd3;
        i_step = 2'd1;
        i_start = 1'b1;
        base = cyc + 1;
        push_exp(4'b0010, base + 10);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 5) timeshift = 1'b0;
            if (k == 6 || k == 8) begin
                checks = checks + 1;
                if (o_time !== CNT_W'(k == 6 ? 2 : 1)) begin
                    errors = errors + 1;
                    $display("FAIL switch_time_k%0d: got %0d, required %0d", k, o_time, (k == 6 ? 2 : 1));
                end
            end
        end
        i_start = 1'b0;
        timeshift = 1'b1;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL switch_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

`ifdef WM_PAUSE_EN
    task automatic test_pause();
        int base;
        @(negedge clk);
        timeshift = 1'b1;
        i_state = 16'd3;
        i_step = 2'd2;
        i_start = 1'b1;
        base = cyc + 1;
        push_exp(4'b0100, base + 45);
        for (int k = 0; k <= 46; k++) begin
            @(negedge clk);
            if (k == 12) i_pause = 1'b1;
            if (k == 27) i_pause = 1'b0;
            if (k == 20 || k == 27 || k == 34) begin
                checks = checks + 1;
                if (o_time !== 16'd2 || o_busy !== 1'b1) begin
                    errors = errors + 1;
                    $display("FAIL pause_hold_k%0d: got time=%0d busy=%b, required 2/1", k, o_time, o_busy);
                end
            end
            if (k == 35) begin
                checks = checks + 1;
                if (o_time !== 16'd1) begin
                    errors = errors + 1;
                    $display("FAIL pause_resume: got %0d, required 1", o_time);
                end
            end
        end
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL pause_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_fast();
        test_chain();
        test_zero();
        test_abort();
        test_reload();
        test_switch();
`ifdef WM_PAUSE_EN
        test_pause();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
